// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 7-segment bus and keeps a debounced decoded code per digit position.
// Define SEG7_HEX_DECODE_EN to also decode the hex letters A..F instead of flagging them invalid.
module seg7_scan_decoder #(
   parameter int unsigned NDIG   = 8,
   parameter int unsigned STABLE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sample,
   input  logic [NDIG-1:0]     an,
   input  logic [6:0]          seg,
   input  logic                err_clr,
   output logic [5*NDIG-1:0]   code,
   output logic [NDIG-1:0]     dvalid,
   output logic                frame_done,
   output logic                err
);

   localparam int unsigned CW           = 4;
   localparam logic [CW-1:0] STABLE_C   = CW'(STABLE);
   localparam logic [4:0]    CODE_BLANK = 5'd16;
   localparam logic [4:0]    CODE_INVAL = 5'd31;

   logic [NDIG-1:0] prev_an;
   logic [6:0]      prev_seg;
   logic [CW-1:0]   cnt;
   logic [NDIG-1:0] seen;

   logic [NDIG-1:0] sel_c;
   logic            onehot_c;
   logic            idle_c;
   logic            legal_c;
   logic            illegal_c;
   logic            match_c;
   logic            accept_c;
   logic            err_set_c;
   logic [4:0]      dec_c;
   logic [CW-1:0]   cnt_next_c;

   // Active-low segment pattern to display code.
   function automatic logic [4:0] decode(input logic [6:0] s);
      logic [4:0] d;
      case (s)
         7'h40:   d = 5'd0;
         7'h79:   d = 5'd1;
         7'h24:   d = 5'd2;
         7'h30:   d = 5'd3;
         7'h19:   d = 5'd4;
         7'h12:   d = 5'd5;
         7'h02:   d = 5'd6;
         7'h78:   d = 5'd7;
         7'h00:   d = 5'd8;
         7'h10:   d = 5'd9;
         7'h7F:   d = 5'd16;
         7'h3F:   d = 5'd17;
`ifdef SEG7_HEX_DECODE_EN
         7'h08:   d = 5'd10;
         7'h03:   d = 5'd11;
         7'h46:   d = 5'd12;
         7'h21:   d = 5'd13;
         7'h06:   d = 5'd14;
         7'h0E:   d = 5'd15;
`endif
         default: d = CODE_INVAL;
      endcase
      return d;
   endfunction

   // Classify the current sample and advance the stability run.
   always_comb begin
      sel_c      = ~an;
      onehot_c   = (sel_c != '0) && ((sel_c & (sel_c - NDIG'(1))) == '0);
      idle_c     = sample && (sel_c == '0);
      legal_c    = sample && onehot_c;
      illegal_c  = sample && (sel_c != '0) && !onehot_c;
      match_c    = (an == prev_an) && (seg == prev_seg);
      dec_c      = decode(seg);
      cnt_next_c = cnt;
      if (idle_c || illegal_c) begin
         cnt_next_c = '0;
      end else if (legal_c) begin
         if (!match_c)
            cnt_next_c = CW'(1);
         else if (cnt != STABLE_C)
            cnt_next_c = cnt + CW'(1);
      end
      // STABLE >= 2, so a reload to 1 can never be the accepting step.
      accept_c  = legal_c && match_c && (cnt == STABLE_C - CW'(1));
      err_set_c = illegal_c || (accept_c && (dec_c == CODE_INVAL));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_an    <= '0;
         prev_seg   <= '0;
         cnt        <= '0;
         seen       <= '0;
         code       <= {NDIG{CODE_BLANK}};
         dvalid     <= '0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         cnt <= cnt_next_c;
         if (legal_c) begin
            prev_an  <= an;
            prev_seg <= seg;
         end
         if (accept_c) begin
            for (int i = 0; i < NDIG; i++) begin
               if (sel_c[i])
                  code[5*i +: 5] <= dec_c;
            end
            dvalid <= dvalid | sel_c;
         end
         // A full mask is reported one edge later; that edge restarts the mask.
         frame_done <= &seen;
         if (&seen)
            seen <= accept_c ? sel_c : '0;
         else if (accept_c)
            seen <= seen | sel_c;
         if (err_set_c)
            err <= 1'b1;
         else if (err_clr)
            err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed and random checks of seg7_scan_decoder against a run-length reference model.
module tb_seg7_scan_decoder;

   localparam int NDIG   = 8;
   localparam int STABLE = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                sample;
   logic [NDIG-1:0]     an;
   logic [6:0]          seg;
   logic                err_clr;
   logic [5*NDIG-1:0]   code;
   logic [NDIG-1:0]     dvalid;
   logic                frame_done;
   logic                err;

   int total = 0;
   int bad   = 0;

   // Patterns: digits 0..9, blank, minus, then hex letters A..F.
   localparam logic [6:0] PATS [18] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                                        7'h78, 7'h00, 7'h10, 7'h7F, 7'h3F, 7'h08, 7'h03,
                                        7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model state
   logic [NDIG-1:0] m_prev_an;
   logic [6:0]      m_prev_seg;
   int              m_run;
   logic [4:0]      m_code [NDIG];
   logic [NDIG-1:0] m_dvalid;
   logic [NDIG-1:0] m_seen;
   logic            m_fd;
   logic            m_err;

   seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
      .clk(clk), .rst_n(rst_n), .sample(sample), .an(an), .seg(seg), .err_clr(err_clr),
      .code(code), .dvalid(dvalid), .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] ref_decode(input logic [6:0] s);
      for (int k = 0; k < 18; k++) begin
         if (PATS[k] == s) begin
            if (k < 10) return 5'(k);
            if (k == 10) return 5'd16;
            if (k == 11) return 5'd17;
`ifdef SEG7_HEX_DECODE_EN
            return 5'(k - 2);
`else
            return 5'd31;
`endif
         end
      end
      return 5'd31;
   endfunction

   task automatic model_edge();
      int nlow;
      int slot;
      logic fd_new;
      logic err_set;
      logic [NDIG-1:0] seen_new;
      if (!rst_n) begin
         m_prev_an = '0; m_prev_seg = '0; m_run = 0;
         for (int i = 0; i < NDIG; i++) m_code[i] = 5'd16;
         m_dvalid = '0; m_seen = '0; m_fd = 1'b0; m_err = 1'b0;
         return;
      end
      fd_new   = (m_seen == '1);
      seen_new = fd_new ? '0 : m_seen;
      err_set  = 1'b0;
      if (sample) begin
         nlow = 0; slot = 0;
         for (int i = 0; i < NDIG; i++) if (!an[i]) begin nlow++; slot = i; end
         if (nlow == 0) begin
            m_run = 0;
         end else if (nlow > 1) begin
            m_run = 0; err_set = 1'b1;
         end else begin
            m_run = (an == m_prev_an && seg == m_prev_seg) ? m_run + 1 : 1;
            m_prev_an = an; m_prev_seg = seg;
            if (m_run == STABLE) begin
               m_code[slot]   = ref_decode(seg);
               m_dvalid[slot] = 1'b1;
               seen_new[slot] = 1'b1;
               if (m_code[slot] == 5'd31) err_set = 1'b1;
            end
         end
      end
      m_seen = seen_new;
      m_fd   = fd_new;
      if (err_set) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
   endtask

   // Drive one clock cycle; outputs are stable on return.
   task automatic step(input logic r, input logic s, input logic [NDIG-1:0] a,
                       input logic [6:0] g, input logic c);
      rst_n = r; sample = s; an = a; seg = g; err_clr = c;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   function automatic logic [NDIG-1:0] an_for(input int s);
      return ~(NDIG'(1) << s);
   endfunction

   task automatic test_reset();
      step(1'b0, 1'b0, '1, 7'h7F, 1'b0);
      step(1'b0, 1'b0, '1, 7'h7F, 1'b0);
      total++;
      if (code !== {NDIG{5'd16}}) begin bad++; $display("FAIL reset_code got=%h want=%h", code, {NDIG{5'd16}}); end
      total++;
      if ({dvalid, frame_done, err} !== '0) begin bad++; $display("FAIL reset_flags got=%b want=0", {dvalid, frame_done, err}); end
   endtask

   task automatic test_stable_digit();
      for (int n = 1; n <= 5; n++) begin
         step(1'b1, 1'b1, 8'hFE, 7'h24, 1'b0);
         if (n == 3) begin
            total++;
            if (dvalid !== 8'h00) begin bad++; $display("FAIL stable_early got=%h want=00", dvalid); end
         end
         if (n >= 4) begin
            total++;
            if (code[4:0] !== 5'd2 || dvalid !== 8'h01 || err !== 1'b0)
               begin bad++; $display("FAIL stable_n%0d got code=%0d dv=%h err=%b want code=2 dv=01 err=0", n, code[4:0], dvalid, err); end
         end
      end
   endtask

   task automatic test_glitch_restart();
      logic saw3 = 1'b0;
      for (int n = 0; n < 7; n++) begin
         step(1'b1, 1'b1, 8'hFD, (n < 3) ? 7'h30 : 7'h19, 1'b0);
         if (code[9:5] === 5'd3) saw3 = 1'b1;
      end
      total++;
      if (saw3 !== 1'b0) begin bad++; $display("FAIL glitch_wrote3 got=1 want=0"); end
      total++;
      if (code[9:5] !== 5'd4 || dvalid[1] !== 1'b1) begin bad++; $display("FAIL glitch_slot1 got=%0d dv=%b want=4 dv=1", code[9:5], dvalid[1]); end
   endtask

   task automatic test_full_frame();
      logic fd_seen = 1'b0;
      step(1'b0, 1'b0, '1, 7'h7F, 1'b0);
      for (int s = 0; s < NDIG; s++)
         for (int n = 0; n < STABLE; n++) begin
            step(1'b1, 1'b1, an_for(s), PATS[s], 1'b0);
            if (frame_done) fd_seen = 1'b1;
         end
      total++;
      if (fd_seen !== 1'b0 || dvalid !== '1) begin bad++; $display("FAIL frame_pre got fd=%b dv=%h want fd=0 dv=ff", fd_seen, dvalid); end
      for (int s = 0; s < NDIG; s++) begin
         total++;
         if (code[5*s +: 5] !== 5'(s)) begin bad++; $display("FAIL frame_code%0d got=%0d want=%0d", s, code[5*s +: 5], s); end
      end
      step(1'b1, 1'b0, '1, 7'h7F, 1'b0);
      total++;
      if (frame_done !== 1'b1) begin bad++; $display("FAIL frame_pulse got=%b want=1", frame_done); end
      step(1'b1, 1'b0, '1, 7'h7F, 1'b0);
      total++;
      if (frame_done !== 1'b0) begin bad++; $display("FAIL frame_width got=%b want=0", frame_done); end
      // Second frame: no pulse until the mask is rebuilt.
      fd_seen = 1'b0;
      for (int s = 0; s < NDIG - 1; s++)
         for (int n = 0; n < STABLE; n++) begin
            step(1'b1, 1'b1, an_for(s), PATS[NDIG - 1 - s], 1'b0);
            if (frame_done) fd_seen = 1'b1;
         end
      total++;
      if (fd_seen !== 1'b0) begin bad++; $display("FAIL frame_mask_cleared got fd=1 want=0"); end
      for (int n = 0; n < STABLE; n++) step(1'b1, 1'b1, an_for(NDIG - 1), 7'h40, 1'b0);
      step(1'b1, 1'b0, '1, 7'h7F, 1'b0);
      total++;
      if (frame_done !== 1'b1) begin bad++; $display("FAIL frame_second got=%b want=1", frame_done); end
   endtask

   task automatic test_errors();
      step(1'b1, 1'b1, 8'hFC, 7'h40, 1'b0);
      total++;
      if (err !== 1'b1) begin bad++; $display("FAIL err_illegal got=%b want=1", err); end
      step(1'b1, 1'b0, '1, 7'h7F, 1'b1);
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", err); end
      step(1'b1, 1'b1, 8'hFC, 7'h40, 1'b1);
      total++;
      if (err !== 1'b1) begin bad++; $display("FAIL err_set_wins got=%b want=1", err); end
      step(1'b1, 1'b0, '1, 7'h7F, 1'b1);
      for (int n = 0; n < STABLE; n++) step(1'b1, 1'b1, 8'hFB, 7'h08, 1'b0);
`ifdef SEG7_HEX_DECODE_EN
      total++;
      if (code[14:10] !== 5'd10 || err !== 1'b0) begin bad++; $display("FAIL err_hexA got code=%0d err=%b want code=10 err=0", code[14:10], err); end
`else
      total++;
      if (code[14:10] !== 5'd31 || err !== 1'b1) begin bad++; $display("FAIL err_hexA got code=%0d err=%b want code=31 err=1", code[14:10], err); end
`endif
      step(1'b1, 1'b0, '1, 7'h7F, 1'b1);
   endtask

   task automatic test_reset_mid_run();
      step(1'b0, 1'b0, '1, 7'h7F, 1'b0);
      step(1'b1, 1'b1, 8'hFE, 7'h40, 1'b0);
      step(1'b1, 1'b1, 8'hFE, 7'h40, 1'b0);
      step(1'b0, 1'b1, 8'hFE, 7'h40, 1'b0);
      step(1'b1, 1'b1, 8'hFE, 7'h40, 1'b0);
      step(1'b1, 1'b1, 8'hFE, 7'h40, 1'b0);
      total++;
      if (dvalid !== '0 || code !== {NDIG{5'd16}}) begin bad++; $display("FAIL midrun got dv=%h code=%h want dv=00 all 16", dvalid, code); end
   endtask

   task automatic test_random();
      logic [NDIG-1:0] a = '1;
      logic [6:0]      g = 7'h7F;
      logic [5*NDIG-1:0] exp_code;
      int r, i, j;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if ($urandom_range(0, 99) < 30) begin
            r = $urandom_range(0, 9);
            i = $urandom_range(0, NDIG - 1);
            if (r == 0) a = '1;
            else if (r == 1) begin
               j = (i + 1 + $urandom_range(0, NDIG - 2)) % NDIG;
               a = an_for(i) & an_for(j);
            end else a = an_for(i);
            r = $urandom_range(0, 19);
            g = (r < 18) ? PATS[r] : ((r == 18) ? 7'h55 : 7'h7E);
         end
         step(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < 85), a, g,
              ($urandom_range(0, 99) < 5));
         for (int k = 0; k < NDIG; k++) exp_code[5*k +: 5] = m_code[k];
         total++;
         if (code !== exp_code || dvalid !== m_dvalid || frame_done !== m_fd || err !== m_err) begin
            bad++;
            $display("FAIL random_c%0d got code=%h dv=%h fd=%b err=%b want code=%h dv=%h fd=%b err=%b",
                     cyc, code, dvalid, frame_done, err, exp_code, m_dvalid, m_fd, m_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_stable_digit();
      test_glitch_restart();
      test_full_frame();
      test_errors();
      test_reset_mid_run();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
